// File: rtl/fec_decoder.sv
// fec_decoder: decodes a pair of Hamming(7,4) codewords into one byte.
// Each word is laid out p1 p2 d1 p3 d2 d3 d4 (bit0..bit6), and a single-bit
// error per word is corrected. The FSM walks IDLE -> SYND -> CORR -> OUT
// and holds the byte in OUT until the downstream side accepts it.
// Optional feature macro: FEC_DEC_ERR_CNT_EN enables the saturating
// corrected-codeword counter on err_cnt; otherwise err_cnt is tied to 0.
module fec_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,      // active-high synchronous reset despite the name
    input  logic             en,
    input  logic             req,
    input  logic [13:0]      code_in,
    output logic             ack,
    output logic [7:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             err_corr,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYND = 2'd1,
        CORR = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] code_q, code_d;
    logic [2:0]  syn_hi_q, syn_hi_d;
    logic [2:0]  syn_lo_q, syn_lo_d;
    logic        ack_q, ack_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        err_corr_q, err_corr_d;

    // Syndrome {s3,s2,s1}; a nonzero value is the 1-based position of the bad bit.
    function automatic logic [2:0] syndrome(input logic [6:0] w);
        logic s1, s2, s3;
        s1 = w[0] ^ w[2] ^ w[4] ^ w[6];
        s2 = w[1] ^ w[2] ^ w[5] ^ w[6];
        s3 = w[3] ^ w[4] ^ w[5] ^ w[6];
        return {s3, s2, s1};
    endfunction

    // Flip bit S-1; a zero syndrome shifts the marker into the discarded bit 0.
    function automatic logic [6:0] correct(input logic [6:0] w, input logic [2:0] s);
        logic [7:0] mask;
        mask = 8'd1 << s;
        return w ^ mask[7:1];
    endfunction

    // Data bits of a corrected word: {d4,d3,d2,d1}.
    function automatic logic [3:0] nibble(input logic [6:0] w);
        return {w[6], w[5], w[4], w[2]};
    endfunction

    // Next-state and next-output logic; en=0 holds everything and squashes ack.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        syn_hi_d     = syn_hi_q;
        syn_lo_d     = syn_lo_q;
        ack_d        = 1'b0;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        err_corr_d   = err_corr_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        code_d  = code_in;
                        ack_d   = 1'b1;
                        state_d = SYND;
                    end
                end
                SYND: begin
                    syn_hi_d = syndrome(code_q[13:7]);
                    syn_lo_d = syndrome(code_q[6:0]);
                    state_d  = CORR;
                end
                CORR: begin
                    data_out_d   = {nibble(correct(code_q[13:7], syn_hi_q)),
                                    nibble(correct(code_q[6:0], syn_lo_q))};
                    err_corr_d   = (syn_hi_q != 3'd0) || (syn_lo_q != 3'd0);
                    data_valid_d = 1'b1;
                    state_d      = OUT;
                end
                OUT: begin
                    if (data_ready) begin
                        data_valid_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and all registered outputs; reset aborts any in-flight word.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            code_q       <= 14'd0;
            syn_hi_q     <= 3'd0;
            syn_lo_q     <= 3'd0;
            ack_q        <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            err_corr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            syn_hi_q     <= syn_hi_d;
            syn_lo_q     <= syn_lo_d;
            ack_q        <= ack_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            err_corr_q   <= err_corr_d;
        end
    end

    // ack_q may already be set when en falls, so gate it to keep ack low while frozen.
    assign ack        = ack_q & en;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign err_corr   = err_corr_q;

`ifdef FEC_DEC_ERR_CNT_EN
    logic [1:0]       n_corr_q, n_corr_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Add the per-byte correction count, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Count corrected words of the byte in CORR, commit on the OUT handshake.
    always_comb begin
        n_corr_d  = n_corr_q;
        err_cnt_d = err_cnt_q;
        if (en && state_q == CORR) begin
            n_corr_d = {1'b0, syn_hi_q != 3'd0} + {1'b0, syn_lo_q != 3'd0};
        end
        if (en && state_q == OUT && data_ready) begin
            err_cnt_d = sat_add(err_cnt_q, n_corr_q);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            n_corr_q  <= 2'd0;
            err_cnt_q <= '0;
        end else begin
            n_corr_q  <= n_corr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fec_decoder.sv
// Testbench for fec_decoder: scoreboard-based, one task per scenario.
module tb_fec_decoder;

`ifdef FEC_DEC_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic        req = 1'b0;
    logic [13:0] code_in = 14'd0;
    logic        data_ready = 1'b1;

    logic        ack, data_valid, err_corr;
    logic [7:0]  data_out;
    logic [15:0] err_cnt;

    logic        ack_s, data_valid_s, err_corr_s;
    logic [7:0]  data_out_s;
    logic [1:0]  err_cnt_s;

    fec_decoder u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .code_in(code_in),
        .ack(ack), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .err_corr(err_corr), .err_cnt(err_cnt)
    );

    fec_decoder #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .code_in(code_in),
        .ack(ack_s), .data_out(data_out_s), .data_valid(data_valid_s),
        .data_ready(data_ready), .err_corr(err_corr_s), .err_cnt(err_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       corr;
        logic [1:0] n;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   cnt_big  = 0;
    int   cnt_small = 0;

    // Reference encoder: word = {d4,d3,d2,p3,d1,p2,p1}.
    function automatic logic [6:0] ham_enc(input logic [3:0] n);
        return {n[3], n[2], n[1], n[1] ^ n[2] ^ n[3], n[0],
                n[0] ^ n[2] ^ n[3], n[0] ^ n[1] ^ n[3]};
    endfunction

    // Nearest-codeword search; the code is perfect so exactly one nibble is within distance 1.
    function automatic exp_t model(input logic [13:0] c);
        exp_t       r;
        logic [6:0] w;
        logic [3:0] nib [2];
        int         nc;
        nc = 0;
        for (int h = 0; h < 2; h++) begin
            w = (h == 1) ? c[13:7] : c[6:0];
            nib[h] = 4'd0;
            for (int n = 0; n < 16; n++) begin
                int d;
                d = $countones(ham_enc(4'(n)) ^ w);
                if (d <= 1) begin
                    nib[h] = 4'(n);
                    if (d == 1) nc++;
                end
            end
        end
        r.data = {nib[1], nib[0]};
        r.corr = (nc != 0);
        r.n    = 2'(nc);
        return r;
    endfunction

    function automatic logic [6:0] rand_word();
        logic [6:0] w;
        w = ham_enc(4'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 1) w = w ^ (7'd1 << $urandom_range(0, 6));
        return w;
    endfunction

    task automatic start_req(input logic [13:0] c);
        code_in = c;
        req = 1'b1;
        exp_q.push_back(model(c));
    endtask

    task automatic count(input logic [1:0] n);
        cnt_big   = (cnt_big + int'(n) > 65535) ? 65535 : cnt_big + int'(n);
        cnt_small = (cnt_small + int'(n) > 3) ? 3 : cnt_small + int'(n);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (ack !== 1'b0 || data_valid !== 1'b0 || data_out !== 8'h00 ||
            err_corr !== 1'b0 || err_cnt !== 16'd0) begin
            $display("FAIL reset_state: ack=%b dv=%b data=%h corr=%b cnt=%0d, want 0 0 00 0 0",
                     ack, data_valid, data_out, err_corr, err_cnt);
        end else pass_cnt++;
        chk_cnt++;
        if (ack_s !== 1'b0 || data_valid_s !== 1'b0 || data_out_s !== 8'h00 ||
            err_corr_s !== 1'b0 || err_cnt_s !== 2'd0) begin
            $display("FAIL reset_state_small: ack=%b dv=%b data=%h corr=%b cnt=%0d, want 0 0 00 0 0",
                     ack_s, data_valid_s, data_out_s, err_corr_s, err_cnt_s);
        end else pass_cnt++;
        rst_n = 1'b0;
        cnt_big = 0;
        cnt_small = 0;
        @(negedge clk);
    endtask

    task automatic test_correction();
        logic [13:0] codes [3];
        exp_t e;
        codes[0] = 14'h292D;
        codes[1] = 14'h293D;
        codes[2] = 14'h29AC;
        data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_req(codes[i]);
            @(negedge clk);
            req = 1'b0;
            chk_cnt++;
            if (ack !== 1'b1) $display("FAIL ack_n1[%0d]: ack=%b, want 1", i, ack);
            else pass_cnt++;
            @(negedge clk);
            chk_cnt++;
            if (ack !== 1'b0 || data_valid !== 1'b0)
                $display("FAIL n2_idle[%0d]: ack=%b dv=%b, want 0 0", i, ack, data_valid);
            else pass_cnt++;
            @(negedge clk);
            e = exp_q.pop_front();
            chk_cnt++;
            if (data_valid !== 1'b1) $display("FAIL dv_n3[%0d]: dv=%b, want 1", i, data_valid);
            else pass_cnt++;
            chk_cnt++;
            if (data_out !== e.data || data_out !== 8'hA5)
                $display("FAIL data[%0d]: data=%h, want %h (A5)", i, data_out, e.data);
            else pass_cnt++;
            chk_cnt++;
            if (err_corr !== e.corr) $display("FAIL corr[%0d]: corr=%b, want %b", i, err_corr, e.corr);
            else pass_cnt++;
            count(e.n);
            @(negedge clk);
            chk_cnt++;
            if (data_valid !== 1'b0 || err_cnt !== (CNT_ON ? 16'(cnt_big) : 16'd0))
                $display("FAIL after_hs[%0d]: dv=%b cnt=%0d, want 0 %0d", i, data_valid, err_cnt,
                         CNT_ON ? cnt_big : 0);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        data_ready = 1'b0;
        start_req(14'h292D);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk_cnt++;
            if (data_valid !== 1'b1 || data_out !== 8'hA5 || data_out !== e.data || ack !== 1'b0)
                $display("FAIL hold[%0d]: dv=%b data=%h ack=%b, want 1 A5 0", k, data_valid, data_out, ack);
            else pass_cnt++;
            if (k == 1) begin
                code_in = 14'h0000;
                req = 1'b1;
            end
            if (k == 3) req = 1'b0;
            if (k == 4) data_ready = 1'b1;
            if (k < 4) @(negedge clk);
        end
        count(e.n);
        @(negedge clk);
        chk_cnt++;
        if (data_valid !== 1'b0) $display("FAIL bp_release: dv=%b, want 0", data_valid);
        else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_cnt++;
            if (data_valid !== 1'b0 || ack !== 1'b0)
                $display("FAIL bp_no_second[%0d]: dv=%b ack=%b, want 0 0", k, data_valid, ack);
            else pass_cnt++;
        end
    endtask

    task automatic test_enable_freeze();
        exp_t e;
        data_ready = 1'b1;
        start_req(14'h293D);
        @(negedge clk);
        req = 1'b0;
        en = 1'b0;
        #1;
        chk_cnt++;
        if (ack !== 1'b0) $display("FAIL ack_forced: ack=%b, want 0", ack);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_cnt++;
            if (data_valid !== 1'b0 || ack !== 1'b0)
                $display("FAIL frozen_synd[%0d]: dv=%b ack=%b, want 0 0", k, data_valid, ack);
            else pass_cnt++;
        end
        en = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (data_valid !== 1'b0 || ack !== 1'b0)
            $display("FAIL resume_corr: dv=%b ack=%b, want 0 0", data_valid, ack);
        else pass_cnt++;
        @(negedge clk);
        e = exp_q.pop_front();
        chk_cnt++;
        if (data_valid !== 1'b1 || data_out !== e.data || err_corr !== e.corr)
            $display("FAIL resume_out: dv=%b data=%h corr=%b, want 1 %h %b",
                     data_valid, data_out, err_corr, e.data, e.corr);
        else pass_cnt++;
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_cnt++;
            if (data_valid !== 1'b1 || data_out !== e.data)
                $display("FAIL frozen_out[%0d]: dv=%b data=%h, want 1 %h", k, data_valid, data_out, e.data);
            else pass_cnt++;
        end
        en = 1'b1;
        count(e.n);
        @(negedge clk);
        chk_cnt++;
        if (data_valid !== 1'b0 || err_cnt !== (CNT_ON ? 16'(cnt_big) : 16'd0))
            $display("FAIL freeze_done: dv=%b cnt=%0d, want 0 %0d", data_valid, err_cnt,
                     CNT_ON ? cnt_big : 0);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_synd();
        data_ready = 1'b1;
        start_req(14'h293D);
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
        cnt_big = 0;
        cnt_small = 0;
        @(negedge clk);
        chk_cnt++;
        if (data_valid !== 1'b0 || ack !== 1'b0 || data_out !== 8'h00 ||
            err_corr !== 1'b0 || err_cnt !== 16'd0 || err_cnt_s !== 2'd0)
            $display("FAIL synd_reset: dv=%b ack=%b data=%h corr=%b cnt=%0d/%0d, want 0 0 00 0 0/0",
                     data_valid, ack, data_out, err_corr, err_cnt, err_cnt_s);
        else pass_cnt++;
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_cnt++;
            if (data_valid !== 1'b0) $display("FAIL aborted_emit[%0d]: dv=%b, want 0", k, data_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        int   want [4];
        exp_t e;
        bit   got;
        want[0] = 1; want[1] = 2; want[2] = 3; want[3] = 3;
        data_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start_req(14'h293D);
            @(negedge clk);
            req = 1'b0;
            got = 1'b0;
            for (int w = 0; w < 6 && !got; w++) begin
                @(negedge clk);
                if (data_valid === 1'b1) got = 1'b1;
            end
            chk_cnt++;
            if (!got) $display("FAIL sat_timeout[%0d]: dv=%b, want 1 within 6 cycles", k, data_valid);
            else pass_cnt++;
            e = exp_q.pop_front();
            if (got) begin
                chk_cnt++;
                if (data_out_s !== e.data || data_out !== e.data)
                    $display("FAIL sat_data[%0d]: data=%h/%h, want %h", k, data_out, data_out_s, e.data);
                else pass_cnt++;
                count(e.n);
                @(negedge clk);
                chk_cnt++;
                if (err_cnt_s !== (CNT_ON ? 2'(want[k]) : 2'd0) ||
                    err_cnt !== (CNT_ON ? 16'(cnt_big) : 16'd0))
                    $display("FAIL sat_cnt[%0d]: small=%0d big=%0d, want %0d %0d", k, err_cnt_s,
                             err_cnt, CNT_ON ? want[k] : 0, CNT_ON ? cnt_big : 0);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int   captured, received, last_t;
        exp_t e;
        captured = 0;
        received = 0;
        last_t = -1;
        data_ready = 1'b1;
        start_req({rand_word(), rand_word()});
        for (int t = 0; t < 80 && received < 6; t++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                captured++;
                if (captured < 6) start_req({rand_word(), rand_word()});
                else req = 1'b0;
            end
            if (data_valid === 1'b1) begin
                chk_cnt++;
                if (err_cnt !== (CNT_ON ? 16'(cnt_big) : 16'd0))
                    $display("FAIL b2b_cnt[%0d]: cnt=%0d, want %0d", received, err_cnt,
                             CNT_ON ? cnt_big : 0);
                else pass_cnt++;
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra[%0d]: data=%h, want no output", received, data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e.data || err_corr !== e.corr)
                        $display("FAIL b2b_data[%0d]: data=%h corr=%b, want %h %b",
                                 received, data_out, err_corr, e.data, e.corr);
                    else pass_cnt++;
                    count(e.n);
                end
                if (last_t >= 0) begin
                    chk_cnt++;
                    if (t - last_t != 4) $display("FAIL b2b_rate[%0d]: interval=%0d, want 4", received, t - last_t);
                    else pass_cnt++;
                end
                last_t = t;
                received++;
            end
        end
        req = 1'b0;
        chk_cnt++;
        if (received != 6) $display("FAIL b2b_count: got %0d bytes, want 6", received);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (err_cnt !== (CNT_ON ? 16'(cnt_big) : 16'd0))
            $display("FAIL b2b_final_cnt: cnt=%0d, want %0d", err_cnt, CNT_ON ? cnt_big : 0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_correction();
        test_backpressure();
        test_enable_freeze();
        test_reset_in_synd();
        test_saturation();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule

// File: doc/fec_decoder.md
FEC_DECODER -- requirements
Module: fec_decoder

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of the correction counter.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (asserted = 1), sampled on the clk rising edge.
REQ-004 The block SHALL have port en, input, 1 bit: block enable.
REQ-005 The block SHALL have port req, input, 1 bit: upstream (demodulator side) codeword request.
REQ-006 The block SHALL have port code_in, input, 14 bits: two Hamming(7,4) codewords; [13:7] carries the high nibble, [6:0] the low nibble.
REQ-007 The block SHALL have port ack, output, 1 bit: one-cycle capture acknowledge.
REQ-008 The block SHALL have port data_out, output, 8 bits: decoded byte.
REQ-009 The block SHALL have port data_valid, output, 1 bit: data_out valid.
REQ-010 The block SHALL have port data_ready, input, 1 bit: downstream accepts data_out.
REQ-011 The block SHALL have port err_corr, output, 1 bit: the current data_out required at least one bit correction.
REQ-012 The block SHALL have port err_cnt, output, CNT_W bits: count of corrected codewords.

Function
REQ-013 The block SHALL decode each codeword at bit index i = position i+1, layout p1 p2 d1 p3 d2 d3 d4 (bit0..bit6).
REQ-014 The block SHALL compute the syndrome as follows: s1 = b0^b2^b4^b6, s2 = b1^b2^b5^b6, s3 = b3^b4^b5^b6, S = {s3,s2,s1}.
REQ-015 When S != 0, the block SHALL invert bit index S-1 before data extraction; when S = 0, it SHALL leave the word unchanged.
REQ-016 The block SHALL extract each nibble as {b6,b5,b4,b2}, and SHALL form data_out as {high nibble, low nibble}.
REQ-017 The block SHALL implement the FSM states IDLE, SYND, CORR and OUT.
REQ-018 In IDLE, when en=1 and req=1 (cycle N), the block SHALL register code_in and SHALL go to SYND.
REQ-019 The block SHALL assert ack in cycle N+1 only, as a single-cycle pulse.
REQ-020 In SYND, the block SHALL register both syndromes and SHALL go to CORR.
REQ-021 In CORR, the block SHALL register the corrected data_out and err_corr, and SHALL go to OUT.
REQ-022 In OUT, the block SHALL hold data_valid=1 with data_out and err_corr stable until data_valid&data_ready; it SHALL then return to IDLE on the next edge with data_valid=0.
REQ-023 The latency from the req capture edge to data_valid SHALL be 3 cycles; maximum throughput SHALL be one byte per 4 cycles.
REQ-024 The block SHALL ignore req in every state other than IDLE.
REQ-025 The requester SHALL drop req after seeing ack; a req still high on return to IDLE SHALL start a new transaction.
REQ-026 When en=0, the block SHALL freeze the FSM, registers and outputs (ack forced 0), and SHALL ignore data_ready.
REQ-027 When en=0 in OUT, data_valid SHALL stay 1 and the transfer SHALL complete only after en returns to 1.
REQ-028 The block SHALL correct single-bit errors per codeword; double errors SHALL be miscorrected silently, with no detection required.

Reset
REQ-029 When rst_n=1 at a clk edge, the block SHALL enter IDLE from any state and SHALL abort any in-flight codeword without emitting it.
REQ-030 Reset values SHALL be: ack=0, data_valid=0, data_out=8'h00, err_corr=0, err_cnt=0, internal code and syndrome registers 0.
REQ-031 Reset SHALL take priority over en, req and data_ready.

Configuration
REQ-032 The macro FEC_DEC_ERR_CNT_EN SHALL control the correction counter.
REQ-033 When FEC_DEC_ERR_CNT_EN is defined, err_cnt SHALL add the number of corrected codewords (0, 1 or 2) in the byte at each OUT handshake, saturating at all-ones with no wrap.
REQ-034 When FEC_DEC_ERR_CNT_EN is not defined, the err_cnt port SHALL remain present and tied to 0, with no counter logic; err_corr SHALL be unaffected.

Verification
REQ-035 The bench SHALL cover: code_in=14'h292D, req pulse, data_ready=1 -> ack at N+1, data_valid at N+3, data_out=8'hA5, err_corr=0, err_cnt=0.
REQ-036 The bench SHALL cover: code_in=14'h293D (bit4 flipped) -> data_out=8'hA5, err_corr=1, err_cnt=1 (macro on) or 0 (macro off).
REQ-037 The bench SHALL cover: code_in=14'h29AC (bit0 of both words flipped) -> data_out=8'hA5, err_corr=1, err_cnt +2.
REQ-038 The bench SHALL cover: code_in=14'h292D with data_ready=0 for 5 cycles -> data_valid held 1, data_out stable 8'hA5, a second req ignored, IDLE one cycle after data_ready=1.
REQ-039 The bench SHALL cover: rst_n=1 asserted in SYND -> next cycle IDLE, data_valid=0, ack=0, data_out=8'h00, err_cnt=0, no byte emitted.
REQ-040 The bench SHALL cover: CNT_W=2, macro on, four single-error bytes -> err_cnt=1,2,3,3 (saturated).
